bcd_feeder: RTL and testbench
=============================

// Module: bcd_feeder
// PURPOSE
//  Memory-mapped binary-to-decimal front end for the 7-segment driver. The CPU
//  writes a plain binary value. The block converts it to packed BCD by
//  iterative double-dabble and then issues one bus write to the display's digit
//  register. Decimal-point writes are forwarded to the display's DP register.
//  Sits on the data bus as a slave. Its master-side port drives the Seg7 bus
//  inputs directly.
// PARAMETERS
//  BASE     32'h20  slave base address; BASE = value, BASE+1 = DP mask/status
//  SEG_BASE 32'h10  display base; digits at SEG_BASE, DP at SEG_BASE+1
//  NDIGITS  4       decimal digits produced (BCD width = 4*NDIGITS)
//  BITS     14      conversion iterations; must be >= ceil(log2(10**NDIGITS))
// PORTS
//  clk         in   1          system clock, all state on posedge
//  reset_n     in   1          asynchronous active-low reset
//  enable      in   1          bus cycle valid
//  rw          in   1          1 = write, 0 = read
//  addr        in   32         bus address
//  data        in   32         bus write data
//  rdata       out  32         read data: {30'b0, ovf, busy} at BASE+1, else 0
//  busy        out  1          conversion or emit pending
//  seg_enable  out  1          one-cycle write strobe to display
//  seg_rw      out  1          write qualifier (equals seg_enable)
//  seg_addr    out  32         display register address
//  seg_data    out  32         {zero-pad, payload} written to display
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE; busy, ovf, seg_enable, seg_rw, seg_addr, seg_data, rdata,
//     dp_pend all 0. A partially converted value is never emitted.
//  Accept:
//   - A write is taken on a posedge when enable & rw & addr in [BASE, BASE+1].
//   - Anything else is ignored; rdata is combinational from addr.
//  Value write (addr==BASE):
//   - Latch data[BITS-1:0] into the shift register and clear the BCD register.
//   - ovf <= (data > 10**NDIGITS-1). The compare uses all 32 bits.
//   - Go to state CONV with iteration counter = BITS.
//  FSM IDLE -> CONV -> EMIT -> IDLE:
//   - CONV, one iteration per clk: add 3 to each BCD nibble >= 5, then shift
//     {bcd, bin} left by 1 and decrement the counter. After the BITS-th shift,
//     go to EMIT.
//   - EMIT: hold seg_enable=seg_rw=1 for exactly one cycle.
//     seg_addr = SEG_BASE; seg_data[4*NDIGITS-1:0] = ovf ? all-F : bcd.
//     Upper seg_data bits are 0. Next state is IDLE.
//   - Latency: the strobe is high in the cycle beginning BITS+1 edges after
//     the accepting edge (15 for defaults).
//   - busy is high from the accepting edge through the end of the EMIT cycle.
//  Restart:
//   - A value write during CONV or EMIT restarts conversion with the new value.
//   - Last writer wins; a pending EMIT for the old value is cancelled.
//   - Exactly one strobe per surviving value.
//  DP write (addr==BASE+1):
//   - Latch data[NDIGITS-1:0] into dp_reg and set dp_pend.
//   - When the output port is free (state != EMIT), emit one strobe with
//     seg_addr = SEG_BASE+1, seg_data = dp_reg. Then clear dp_pend.
//   - A digit EMIT has priority; the DP strobe follows in the next free cycle.
//   - A second DP write while pending overwrites dp_reg; one strobe is emitted.
//  Outputs:
//   - Master outputs are registered.
//   - seg_addr and seg_data hold their last values when seg_enable=0.
//   - Never two strobes in one cycle; the arbitration guarantees this.
//  ovf:
//   - Sticky until the next value write.
//   - Status read during CONV reports busy=1 and the new ovf.
// TESTING
//  1. Write 1234 @BASE -> busy=1. 15 edges later: one seg_enable pulse,
//     seg_addr=0x10, seg_data=0x1234. busy=0 next cycle.
//  2. Write 9999 -> seg_data=0x9999, ovf=0. Write 10000 -> 0xFFFF, status
//     read=0x2. Write 0 -> 0x0000, ovf cleared.
//  3. Write 42, then write 7 on the 5th CONV cycle -> single pulse,
//     seg_data=0x0007. No 0x0042 is ever emitted.
//  4. DP write 0x5 @BASE+1 during EMIT -> digit strobe first. Next cycle:
//     strobe with seg_addr=0x11, seg_data=0x5.
//  5. Assert reset_n=0 mid-CONV -> outputs 0 immediately, no strobe.
//     After release, write 56 -> 0x0056 with normal latency.
//  6. enable=0, rw=0, or addr=BASE+2 with data=123 -> no state change, no
//     strobe. Read @BASE+1 while idle -> rdata=0.

Source files
------------

// File: rtl/bcd_feeder.sv
// Bus slave that converts a written binary value to packed BCD by iterative
// double-dabble and forwards digit and decimal-point writes to the display.
module bcd_feeder #(
  parameter logic [31:0] BASE     = 32'h20,
  parameter logic [31:0] SEG_BASE = 32'h10,
  parameter int          NDIGITS  = 4,
  parameter int          BITS     = 14
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        seg_enable,
  output logic        seg_rw,
  output logic [31:0] seg_addr,
  output logic [31:0] seg_data
);

  localparam int              BW          = 4 * NDIGITS;
  localparam int              CW          = $clog2(BITS + 1);
  localparam logic [31:0]     DP_ADDR     = BASE + 32'd1;
  localparam logic [31:0]     SEG_DP_ADDR = SEG_BASE + 32'd1;
  localparam logic [31:0]     MAX_VAL     = 32'(10 ** NDIGITS - 1);
  localparam logic [CW-1:0]   CNT_INIT    = CW'(BITS);

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  state_t              state, state_next;
  logic [BITS-1:0]     bin;
  logic [BW-1:0]       bcd, bcd_adj;
  logic [CW-1:0]       cnt;
  logic                ovf;
  logic [NDIGITS-1:0]  dp_reg;
  logic                dp_pend;
  logic                val_wr, dp_wr, conv_done, digit_load;

  assign val_wr     = enable & rw & (addr == BASE);
  assign dp_wr      = enable & rw & (addr == DP_ADDR);
  assign conv_done  = (state == CONV) && (cnt == '0);
  assign digit_load = (state_next == EMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A value write from any state restarts conversion, cancelling any pending emit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      CONV:    if (conv_done) state_next = EMIT;
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (val_wr) state_next = CONV;
  end

  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd[4*gi +: 4] >= 4'd5) ? bcd[4*gi +: 4] + 4'd3
                                                            : bcd[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (val_wr) begin
      bin <= data[BITS-1:0];
      bcd <= '0;
      cnt <= CNT_INIT;
      ovf <= (data > MAX_VAL);
    end else if (state == CONV && cnt != '0) begin
      {bcd, bin} <= {bcd_adj[BW-2:0], bin, 1'b0};
      cnt        <= cnt - 1'b1;
    end
  end

  // Output port arbitration: digit emit wins, a pending DP write takes the next free cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_enable <= 1'b0;
      seg_rw     <= 1'b0;
      seg_addr   <= '0;
      seg_data   <= '0;
      dp_reg     <= '0;
      dp_pend    <= 1'b0;
    end else begin
      if (digit_load) begin
        seg_enable <= 1'b1;
        seg_rw     <= 1'b1;
        seg_addr   <= SEG_BASE;
        seg_data   <= 32'(ovf ? {BW{1'b1}} : bcd);
      end else if (dp_pend) begin
        seg_enable <= 1'b1;
        seg_rw     <= 1'b1;
        seg_addr   <= SEG_DP_ADDR;
        seg_data   <= 32'(dp_reg);
        dp_pend    <= 1'b0;
      end else begin
        seg_enable <= 1'b0;
        seg_rw     <= 1'b0;
      end
      if (dp_wr) begin
        dp_reg  <= data[NDIGITS-1:0];
        dp_pend <= 1'b1;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign rdata = (addr == DP_ADDR) ? {30'b0, ovf, busy} : 32'b0;

endmodule

// File: tb/tb_bcd_feeder.sv
// Randomized scoreboard bench for bcd_feeder: an edge-level reference model
// predicts every display write and the monitor checks each strobe as it appears.
module tb_bcd_feeder;

  localparam logic [31:0] BASE     = 32'h20;
  localparam logic [31:0] SEG_BASE = 32'h10;
  localparam int          BITS     = 14;
  localparam logic [31:0] MAXV     = 32'd9999;

  localparam int OP_IDLE = 0, OP_VAL = 1, OP_DP = 2, OP_RD = 3, OP_JUNK = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        seg_enable;
  logic        seg_rw;
  logic [31:0] seg_addr;
  logic [31:0] seg_data;

  bcd_feeder #(.BASE(BASE), .SEG_BASE(SEG_BASE), .NDIGITS(4), .BITS(BITS)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rw(rw), .addr(addr),
    .data(data), .rdata(rdata), .busy(busy), .seg_enable(seg_enable),
    .seg_rw(seg_rw), .seg_addr(seg_addr), .seg_data(seg_data)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          e;
  } exp_t;
  exp_t q[$];

  // Reference model state, expressed in bus transactions and edge numbers
  bit          conv_active = 0;
  int          conv_start  = 0;
  logic [31:0] conv_val    = '0;
  bit          ovf_m       = 0;
  bit          dp_pend_m   = 0;
  logic [3:0]  dp_val_m    = '0;
  int          last_fire   = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r = '0;
    int unsigned div = 1;
    for (int d = 0; d < 4; d++) begin
      r |= ((v / div) % 10) << (4 * d);
      div *= 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit vw, input bit dw, input logic [31:0] d, input int e);
    bit   fire;
    exp_t x;
    fire = conv_active && (e == conv_start + BITS + 1) && !vw;
    if (vw) begin
      conv_active = 1;
      conv_start  = e;
      conv_val    = d;
      ovf_m       = (d > MAXV);
    end
    if (fire) begin
      x.a = SEG_BASE;
      x.d = (conv_val > MAXV) ? 32'h0000FFFF : to_bcd(conv_val);
      x.e = e;
      q.push_back(x);
      conv_active = 0;
      last_fire   = e;
    end else if (dp_pend_m) begin
      x.a = SEG_BASE + 32'd1;
      x.d = {28'b0, dp_val_m};
      x.e = e;
      q.push_back(x);
      dp_pend_m = 0;
    end
    if (dw) begin
      dp_val_m  = d[3:0];
      dp_pend_m = 1;
    end
  endtask

  task automatic cycle(input int op, input logic [31:0] d);
    bit busy_m;
    @(negedge clk);
    enable = 1'b0; rw = 1'b0; addr = '0; data = d;
    case (op)
      OP_VAL: begin enable = 1'b1; rw = 1'b1; addr = BASE; end
      OP_DP:  begin enable = 1'b1; rw = 1'b1; addr = BASE + 32'd1; end
      OP_RD:  begin enable = 1'b1; rw = 1'b0; addr = BASE + 32'd1; end
      OP_JUNK: begin
        case ($urandom_range(0, 3))
          0: begin enable = 1'b0; rw = 1'b1; addr = BASE; end
          1: begin enable = 1'b1; rw = 1'b0; addr = BASE; end
          2: begin enable = 1'b1; rw = 1'b1; addr = BASE + 32'd2; end
          default: begin enable = 1'b1; rw = 1'b1; addr = BASE - 32'd1; end
        endcase
      end
      default: ;
    endcase
    #1;
    busy_m = conv_active || (last_fire == edge_cnt);
    if (op == OP_RD)   chk("status_read", rdata, {30'b0, ovf_m, busy_m});
    if (op == OP_JUNK) chk("junk_rdata", rdata, 32'h0);
    if (op == OP_VAL)  $display("write value %0d at edge %0d", d, edge_cnt + 1);
    model_step(op == OP_VAL, op == OP_DP, d, edge_cnt + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(OP_IDLE, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; enable = 1'b1; rw = 1'b0; addr = BASE + 32'd1;
    #1;
    chk("rst_seg_enable", {31'b0, seg_enable}, 32'h0);
    chk("rst_seg_rw", {31'b0, seg_rw}, 32'h0);
    chk("rst_seg_addr", seg_addr, 32'h0);
    chk("rst_seg_data", seg_data, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    conv_active = 0; dp_pend_m = 0; ovf_m = 0; last_fire = -1;
    @(negedge clk);
    reset_n = 1'b1; enable = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest prediction, at its predicted edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (seg_rw !== seg_enable) chk("seg_rw_eq_enable", {31'b0, seg_rw}, {31'b0, seg_enable});
      if (seg_enable === 1'b1) begin
        $display("strobe at edge %0d addr=0x%0h data=0x%0h", edge_cnt, seg_addr, seg_data);
        if (q.size() == 0) begin
          chk("unexpected_strobe", seg_addr, 32'hxxxx_xxxx);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("strobe_addr", seg_addr, x.a);
          chk("strobe_data", seg_data, x.d);
          chk("strobe_edge", 32'(edge_cnt), 32'(x.e));
        end
      end else if (q.size() != 0 && q[0].e <= edge_cnt) begin
        exp_t x;
        x = q.pop_front();
        chk("missing_strobe", {31'b0, seg_enable}, 32'h1);
      end
    end
  end

  initial begin
    int r;
    logic [31:0] v;
    addr = BASE + 32'd1;
    #3;
    chk("init_seg_enable", {31'b0, seg_enable}, 32'h0);
    chk("init_seg_addr", seg_addr, 32'h0);
    chk("init_seg_data", seg_data, 32'h0);
    chk("init_busy", {31'b0, busy}, 32'h0);
    chk("init_rdata", rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Basic conversion, busy visible right after the write
    cycle(OP_VAL, 32'd1234);
    cycle(OP_RD, 32'h0);
    idle(20);
    cycle(OP_RD, 32'h0);

    // Range boundaries and sticky overflow
    cycle(OP_VAL, 32'd9999);  idle(17);
    cycle(OP_VAL, 32'd10000); idle(17);
    cycle(OP_RD, 32'h0);
    cycle(OP_VAL, 32'd0);     idle(17);
    cycle(OP_RD, 32'h0);

    // Restart on the 5th conversion cycle
    cycle(OP_VAL, 32'd42); idle(4);
    cycle(OP_VAL, 32'd7);  idle(18);

    // DP write during the digit emit cycle
    cycle(OP_VAL, 32'd321); idle(15);
    cycle(OP_DP, 32'h5);    idle(5);

    // Reset in the middle of a conversion
    cycle(OP_VAL, 32'd555); idle(5);
    do_reset();
    cycle(OP_VAL, 32'd56); idle(18);

    // Non-accepted bus cycles leave everything alone
    for (int i = 0; i < 8; i++) cycle(OP_JUNK, 32'd123);
    cycle(OP_RD, 32'h0);
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        case ($urandom_range(0, 9))
          0: v = 32'd9999;
          1: v = 32'd10000;
          2, 3: v = $urandom;
          default: v = $urandom_range(0, 9999);
        endcase
        cycle(OP_VAL, v);
      end else if (r < 9)  cycle(OP_DP, $urandom);
      else if (r < 25)     cycle(OP_RD, 32'h0);
      else if (r < 40)     cycle(OP_JUNK, $urandom);
      else                 cycle(OP_IDLE, 32'h0);
    end

    idle(40);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
